// File: rtl/md5_core_scheduler_if.sv
// Candidate stream and per-core MD5 bus shared between the scheduler and its environment.
// The master side is the scheduler: it accepts candidates and drives the cores' message inputs.
interface md5_core_scheduler_if #(
    parameter int NUM_CORES = 2,
    parameter int MSG_W     = 128,
    parameter int DIG_W     = 128,
    parameter int IDX_W     = 48
);
    logic                       cand_valid;
    logic                       cand_ready;
    logic [MSG_W-1:0]           cand_msg;
    logic [IDX_W-1:0]           cand_idx;

    logic [NUM_CORES*MSG_W-1:0] core_msg;
    logic [NUM_CORES-1:0]       core_msg_valid;
    logic [NUM_CORES-1:0]       core_ready;
    logic [NUM_CORES*DIG_W-1:0] core_digest;
    logic [NUM_CORES-1:0]       core_out_valid;

    modport master (
        input  cand_valid, cand_msg, cand_idx, core_ready, core_digest, core_out_valid,
        output cand_ready, core_msg, core_msg_valid
    );

    modport slave (
        output cand_valid, cand_msg, cand_idx, core_ready, core_digest, core_out_valid,
        input  cand_ready, core_msg, core_msg_valid
    );
endinterface

// File: rtl/md5_core_scheduler.sv
// Round-robin dispatch of candidates to NUM_CORES MD5 cores; tracks each core's candidate
// so that a digest match reports the cleartext that actually produced it.
module md5_core_scheduler #(
    parameter int NUM_CORES = 2,
    parameter int MSG_W     = 128,
    parameter int DIG_W     = 128,
    parameter int IDX_W     = 48,
    parameter int CID_W     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 clear,
    input  logic [DIG_W-1:0]     target,
    md5_core_scheduler_if.master bus,
    output logic                 found,
    output logic [MSG_W-1:0]     found_msg,
    output logic [IDX_W-1:0]     found_idx,
    output logic [CID_W-1:0]     found_core,
    output logic                 busy,
    output logic [IDX_W-1:0]     hash_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FOUND
    } state_t;

    state_t                     state, state_next;
    logic [CID_W-1:0]           rr_ptr;
    logic [NUM_CORES-1:0]       inflight;
    logic [NUM_CORES*MSG_W-1:0] core_msg_r;
    logic [NUM_CORES-1:0]       core_msg_valid_r;
    logic [MSG_W-1:0]           tag_msg [NUM_CORES];
    logic [IDX_W-1:0]           tag_idx [NUM_CORES];

    logic [NUM_CORES-1:0]       free, done, match_vec, sel_oh;
    logic                       match_now, xfer, sel_hit, win_hit;
    logic [CID_W-1:0]           sel_core, win_core, rr_next;
    logic [MSG_W-1:0]           win_msg;
    logic [IDX_W-1:0]           win_idx;
    logic [3:0]                 pop;
    logic [IDX_W:0]             hash_sum;
    logic [IDX_W-1:0]           hash_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        free      = bus.core_ready & ~inflight;
        done      = bus.core_out_valid & inflight;
        match_vec = '0;
        pop       = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            match_vec[k] = done[k] & (bus.core_digest[k*DIG_W +: DIG_W] == target);
            pop          = pop + {3'b000, done[k]};
        end
        match_now = (state == S_RUN) & (|match_vec);

        win_hit  = 1'b0;
        win_core = '0;
        win_msg  = '0;
        win_idx  = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (match_vec[k] && !win_hit) begin
                win_hit  = 1'b1;
                win_core = CID_W'(k);
                win_msg  = tag_msg[k];
                win_idx  = tag_idx[k];
            end
        end

        // Cyclic search from rr_ptr: first pass covers rr_ptr..N-1, second wraps to 0.
        sel_hit  = 1'b0;
        sel_core = '0;
        sel_oh   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (free[k] && !sel_hit && k >= int'(rr_ptr)) begin
                sel_hit   = 1'b1;
                sel_core  = CID_W'(k);
                sel_oh    = '0;
                sel_oh[k] = 1'b1;
            end
        end
        for (int k = 0; k < NUM_CORES; k++) begin
            if (free[k] && !sel_hit) begin
                sel_hit   = 1'b1;
                sel_core  = CID_W'(k);
                sel_oh    = '0;
                sel_oh[k] = 1'b1;
            end
        end
        rr_next = (sel_core == CID_W'(NUM_CORES - 1)) ? '0 : sel_core + CID_W'(1);

        bus.cand_ready = (state == S_RUN) & ~clear & sel_hit & ~match_now;
        xfer           = bus.cand_valid & bus.cand_ready;

        hash_sum  = {1'b0, hash_count} + {{(IDX_W-3){1'b0}}, pop};
        hash_next = hash_sum[IDX_W] ? '1 : hash_sum[IDX_W-1:0];

        busy = (state == S_RUN) & (|inflight);
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (start)     state_next = S_RUN;
                S_RUN:   if (match_now) state_next = S_FOUND;
                S_FOUND: state_next = S_FOUND;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: the per-core tag storage is reset too; a stale tag must never reach found_msg.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr           <= '0;
            inflight         <= '0;
            core_msg_r       <= '0;
            core_msg_valid_r <= '0;
            found            <= 1'b0;
            found_msg        <= '0;
            found_idx        <= '0;
            found_core       <= '0;
            hash_count       <= '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                tag_msg[k] <= '0;
                tag_idx[k] <= '0;
            end
        end else if (clear) begin
            rr_ptr           <= '0;
            inflight         <= '0;
            core_msg_valid_r <= '0;
            found            <= 1'b0;
            found_msg        <= '0;
            found_idx        <= '0;
            found_core       <= '0;
            hash_count       <= '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                tag_msg[k] <= '0;
                tag_idx[k] <= '0;
            end
        end else begin
            // A completing core is never free, so issue and completion never hit the same bit.
            inflight         <= (inflight & ~done) | (xfer ? sel_oh : '0);
            core_msg_valid_r <= xfer ? sel_oh : '0;
            hash_count       <= hash_next;
            if (xfer) begin
                rr_ptr <= rr_next;
                for (int k = 0; k < NUM_CORES; k++) begin
                    if (sel_oh[k]) begin
                        core_msg_r[k*MSG_W +: MSG_W] <= bus.cand_msg;
                        tag_msg[k]                   <= bus.cand_msg;
                        tag_idx[k]                   <= bus.cand_idx;
                    end
                end
            end
            if (match_now) begin
                found      <= 1'b1;
                found_msg  <= win_msg;
                found_idx  <= win_idx;
                found_core <= win_core;
            end
        end
    end

    assign bus.core_msg       = core_msg_r;
    assign bus.core_msg_valid = core_msg_valid_r;

endmodule

// File: tb/tb_md5_core_scheduler.sv
// Directed bench for md5_core_scheduler with two cores; the bench plays both MD5 cores.
module tb_md5_core_scheduler;

    localparam int NUM_CORES = 2;
    localparam int MSG_W     = 128;
    localparam int DIG_W     = 128;
    localparam int IDX_W     = 48;
    localparam int CID_W     = 3;
    localparam logic [DIG_W-1:0] TGT = 128'h9ffaf8351cd571fabeb210c0170608ef;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             clear;
    logic [DIG_W-1:0] target;
    logic             found;
    logic [MSG_W-1:0] found_msg;
    logic [IDX_W-1:0] found_idx;
    logic [CID_W-1:0] found_core;
    logic             busy;
    logic [IDX_W-1:0] hash_count;

    int n_checks = 0;
    int n_pass   = 0;

    md5_core_scheduler_if #(
        .NUM_CORES(NUM_CORES), .MSG_W(MSG_W), .DIG_W(DIG_W), .IDX_W(IDX_W)
    ) bus ();

    md5_core_scheduler #(
        .NUM_CORES(NUM_CORES), .MSG_W(MSG_W), .DIG_W(DIG_W), .IDX_W(IDX_W), .CID_W(CID_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .clear      (clear),
        .target     (target),
        .bus        (bus.master),
        .found      (found),
        .found_msg  (found_msg),
        .found_idx  (found_idx),
        .found_core (found_core),
        .busy       (busy),
        .hash_count (hash_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [MSG_W-1:0] cmsg(input logic [IDX_W-1:0] i);
        return {16'hCAFE, 64'h0123_4567_89AB_CDEF, i};
    endfunction

    task automatic set_cand(input logic v, input logic [IDX_W-1:0] i);
        bus.cand_valid = v;
        bus.cand_idx   = i;
        bus.cand_msg   = cmsg(i);
    endtask

    // One-cycle completion pulse on the cores in mask, each presenting digest d.
    task automatic complete(input logic [NUM_CORES-1:0] mask, input logic [DIG_W-1:0] d);
        bus.core_out_valid = mask;
        bus.core_digest    = {d, d};
        @(negedge clk);
        bus.core_out_valid = '0;
        bus.core_digest    = '0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within its time budget");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; clear = 1'b0; target = TGT;
        bus.core_ready = 2'b11; bus.core_out_valid = '0; bus.core_digest = '0;
        set_cand(1'b1, 48'd0);
        repeat (2) @(negedge clk);
        check("rst_found",  found, 0);
        check("rst_hash",   hash_count, 0);
        check("rst_mvalid", bus.core_msg_valid, 0);
        check("rst_cmsg",   bus.core_msg, 0);
        check("rst_busy",   busy, 0);
        check("rst_cready", bus.cand_ready, 0);
        reset = 1'b0;

        // Round-robin fill: idx0 -> core0, idx1 -> core1, then stall.
        @(negedge clk);
        check("idle_cready", bus.cand_ready, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("run_cready", bus.cand_ready, 1);
        @(negedge clk);
        check("rr0_mvalid", bus.core_msg_valid, 2'b01);
        check("rr0_msg",    bus.core_msg[0 +: MSG_W], cmsg(48'd0));
        check("rr0_busy",   busy, 1);
        set_cand(1'b1, 48'd1);
        #1 check("rr1_cready", bus.cand_ready, 1);
        @(negedge clk);
        check("rr1_mvalid", bus.core_msg_valid, 2'b10);
        check("rr1_msg",    bus.core_msg[MSG_W +: MSG_W], cmsg(48'd1));
        set_cand(1'b1, 48'd2);
        #1 check("full_cready", bus.cand_ready, 0);
        @(negedge clk);
        check("pulse_once", bus.core_msg_valid, 2'b00);
        check("hold_msg0",  bus.core_msg[0 +: MSG_W], cmsg(48'd0));
        complete(2'b10, 128'h0);
        check("hash_1", hash_count, 1);
        #1 check("free1_cready", bus.cand_ready, 1);
        @(negedge clk);
        check("rr2_mvalid", bus.core_msg_valid, 2'b10);
        check("rr2_msg",    bus.core_msg[MSG_W +: MSG_W], cmsg(48'd2));
        set_cand(1'b0, 48'd0);
        complete(2'b01, 128'h0);
        complete(2'b10, 128'h1);
        check("hash_3", hash_count, 3);
        check("idle_busy", busy, 0);

        // Stray completion on an idle core carrying the target digest.
        complete(2'b01, TGT);
        check("stray_found", found, 0);
        check("stray_hash",  hash_count, 3);

        // idx5 lands on core1 (core0 not ready), idx6 on core0, core1 matches.
        bus.core_ready = 2'b10;
        set_cand(1'b1, 48'd5);
        @(negedge clk);
        check("mask_mvalid", bus.core_msg_valid, 2'b10);
        bus.core_ready = 2'b11;
        set_cand(1'b1, 48'd6);
        @(negedge clk);
        check("i6_mvalid", bus.core_msg_valid, 2'b01);
        check("i6_msg",    bus.core_msg[0 +: MSG_W], cmsg(48'd6));
        set_cand(1'b1, 48'd7);
        bus.core_out_valid = 2'b10;
        bus.core_digest    = {TGT, 128'h0};
        @(negedge clk);
        bus.core_out_valid = '0;
        check("m1_found", found, 1);
        check("m1_core",  found_core, 1);
        check("m1_idx",   found_idx, 5);
        check("m1_msg",   found_msg, cmsg(48'd5));
        check("m1_hash",  hash_count, 4);
        check("m1_busy",  busy, 0);
        check("m1_cready", bus.cand_ready, 0);
        complete(2'b01, TGT);
        check("late_hash", hash_count, 5);
        check("late_core", found_core, 1);
        check("late_idx",  found_idx, 5);
        check("late_mvalid", bus.core_msg_valid, 2'b00);

        // Both cores match in the same cycle: core0 wins, count steps by 2.
        pulse_clear();
        check("clr_found", found, 0);
        check("clr_hash",  hash_count, 0);
        start = 1'b1;
        set_cand(1'b1, 48'd8);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("i8_mvalid", bus.core_msg_valid, 2'b01);
        set_cand(1'b1, 48'd9);
        @(negedge clk);
        check("i9_mvalid", bus.core_msg_valid, 2'b10);
        set_cand(1'b0, 48'd0);
        complete(2'b11, TGT);
        check("sim_core", found_core, 0);
        check("sim_idx",  found_idx, 8);
        check("sim_msg",  found_msg, cmsg(48'd8));
        check("sim_hash", hash_count, 2);

        // clear wins over a match in the same cycle.
        pulse_clear();
        start = 1'b1;
        set_cand(1'b1, 48'd10);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("i10_mvalid", bus.core_msg_valid, 2'b01);
        set_cand(1'b1, 48'd11);
        clear = 1'b1;
        bus.core_out_valid = 2'b01;
        bus.core_digest    = {128'h0, TGT};
        #1 check("cm_cready", bus.cand_ready, 0);
        @(negedge clk);
        clear = 1'b0;
        bus.core_out_valid = '0;
        check("cm_found",  found, 0);
        check("cm_hash",   hash_count, 0);
        check("cm_cready_idle", bus.cand_ready, 0);
        check("cm_busy",   busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("i11_mvalid", bus.core_msg_valid, 2'b01);
        check("i11_msg",    bus.core_msg[0 +: MSG_W], cmsg(48'd11));
        set_cand(1'b1, 48'd12);
        bus.core_out_valid = 2'b01;
        bus.core_digest    = {128'h0, TGT};
        #1 check("match_blocks_cready", bus.cand_ready, 0);
        @(negedge clk);
        bus.core_out_valid = '0;
        check("i11_found", found, 1);
        check("i11_idx",   found_idx, 11);
        check("i11_core",  found_core, 0);
        check("i11_noissue", bus.core_msg_valid, 2'b00);

        // Asynchronous reset with both cores inflight and an issue about to happen.
        pulse_clear();
        start = 1'b1;
        set_cand(1'b1, 48'd12);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        set_cand(1'b1, 48'd13);
        @(negedge clk);
        set_cand(1'b1, 48'd14);
        complete(2'b01, 128'h0);
        check("pre_rst_hash", hash_count, 1);
        check("pre_rst_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_hash",   hash_count, 0);
        check("arst_mvalid", bus.core_msg_valid, 0);
        check("arst_cmsg",   bus.core_msg, 0);
        check("arst_busy",   busy, 0);
        check("arst_cready", bus.cand_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_quiet", bus.core_msg_valid, 2'b00);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("post_rst_mvalid", bus.core_msg_valid, 2'b01);
        check("post_rst_msg",    bus.core_msg[0 +: MSG_W], cmsg(48'd14));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
